uart_rx_frame: RTL

//  UART receive deframer; sits directly downstream of the baud-rate generator (BaudControl).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_frame.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry defaults, receiver state encoding, parity sense.
// Used by the RX deframer, the transmitter and BaudControl.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    // XOR across data bits plus parity bit that a correct even-parity frame produces.
    localparam logic PARITY_EVEN = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle (high) line never looks like a start bit after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: recovers 8N1/8E1 frames from an oversampled serial line and
// presents each byte with a one-cycle valid plus parity and framing error flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output rx_state_e            state_dbg
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    rx_state_e            state, state_n;
    logic [OS_W-1:0]      os_cnt, os_cnt_n;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 perr, perr_n;
    logic                 par_lat, par_lat_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n, parity_err_n, frame_err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            par_lat    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            os_cnt     <= os_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            perr       <= perr_n;
            par_lat    <= par_lat_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        os_cnt_n     = os_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        perr_n       = perr;
        par_lat_n    = par_lat;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;

        case (state)
            IDLE: begin
                if (baud_tick && !rx_s) begin
                    state_n  = START;
                    os_cnt_n = '0;
                end
            end
            START: begin
                // Mid-start-bit recheck rejects line glitches shorter than half a bit.
                if (baud_tick) begin
                    if (os_cnt == OS_MID) begin
                        if (!rx_s) begin
                            state_n   = DATA;
                            os_cnt_n  = '0;
                            bit_cnt_n = '0;
                            perr_n    = 1'b0;
                            par_lat_n = parity_en;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (os_cnt == OS_LAST) begin
                        shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                        os_cnt_n  = '0;
                        bit_cnt_n = bit_cnt + BC_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_n = par_lat ? PARITY : STOP;
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (os_cnt == OS_LAST) begin
                        perr_n   = (^{shift, rx_s}) ^ PARITY_EVEN;
                        os_cnt_n = '0;
                        state_n  = STOP;
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (os_cnt == OS_LAST) begin
                        rx_data_n    = shift;
                        rx_valid_n   = 1'b1;
                        parity_err_n = par_lat & perr;
                        frame_err_n  = ~rx_s;
                        os_cnt_n     = '0;
                        state_n      = rx_s ? IDLE : BREAK;
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
            end
            BREAK: begin
                // A line held low must return high before another start is accepted.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
